// File: rtl/cam_rgb_to_raw.sv
// cam_rgb_to_raw: re-mosaics a 2-pixel-per-clock RGB stream into a 2PPC raw
// Bayer stream. Each lane keeps only the colour its CFA site would have sensed,
// scaled by a per-channel gain that is sampled once per frame.
// Pipeline: stage 1 picks the colour and gain per lane, stage 2 multiplies and
// saturates. Latency is two clocks for data, sync and framing flags alike.
module cam_rgb_to_raw #(
    parameter int P_DEPTH       = 10,
    parameter int PW            = P_DEPTH * 2,
    parameter int FRAME_WIDTH   = 640,
    parameter int FRAME_HEIGHT  = 480,
    parameter int BAYER_PATTERN = 0,
    parameter int GAIN_FRAC     = 6
) (
    input  logic          i_pclk,
    input  logic          i_arst,
    input  logic          i_vsync,
    input  logic          i_valid,
    input  logic [PW-1:0] i_r,
    input  logic [PW-1:0] i_g,
    input  logic [PW-1:0] i_b,
    input  logic [7:0]    i_gain_r,
    input  logic [7:0]    i_gain_g,
    input  logic [7:0]    i_gain_b,
    output logic          o_vsync,
    output logic          o_valid,
    output logic [PW-1:0] o_raw,
    output logic          o_sol,
    output logic          o_eol
);

    localparam int BEATS = FRAME_WIDTH / 2;
    localparam int PCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LCW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int MW    = P_DEPTH + 8;
    localparam logic [PCW-1:0] LAST_BEAT = PCW'(BEATS - 1);
    localparam logic [LCW-1:0] LAST_LINE = LCW'(FRAME_HEIGHT - 1);
    localparam logic [MW-1:0]  SAT_MAX   = MW'((2 ** P_DEPTH) - 1);
    localparam logic [7:0]     UNITY     = 8'(2 ** GAIN_FRAC);

    typedef enum logic [1:0] {
        COL_R,
        COL_G,
        COL_B
    } colour_t;

    logic               vsync_q;
    logic               fs;
    logic [PCW-1:0]     pixel_count, eff_pix, pixel_next;
    logic [LCW-1:0]     line_count, eff_line, line_next;
    logic [7:0]         gain_r_q, gain_g_q, gain_b_q;
    logic [7:0]         gain_r_eff, gain_g_eff, gain_b_eff;
    colour_t            col0, col1;
    logic [P_DEPTH-1:0] samp0, samp1;
    logic [7:0]         gain0, gain1;

    logic               s1_valid, s1_sol, s1_eol;
    logic [P_DEPTH-1:0] s1_samp0, s1_samp1;
    logic [7:0]         s1_gain0, s1_gain1;

    logic [MW-1:0]      prod0, prod1, shift0, shift1;
    logic [P_DEPTH-1:0] sat0, sat1;

    // Frame start is the falling edge of vsync; the fs beat itself is (0,0)
    // and already sees the gains that are being latched for the new frame.
    assign fs         = vsync_q & ~i_vsync;
    assign gain_r_eff = fs ? i_gain_r : gain_r_q;
    assign gain_g_eff = fs ? i_gain_g : gain_g_q;
    assign gain_b_eff = fs ? i_gain_b : gain_b_q;

    // Effective coordinates of the current beat and the counter values that follow it.
    always_comb begin
        eff_pix    = fs ? '0 : pixel_count;
        eff_line   = fs ? '0 : line_count;
        pixel_next = eff_pix;
        line_next  = eff_line;
        if (i_valid) begin
            if (eff_pix == LAST_BEAT) begin
                pixel_next = '0;
                line_next  = (eff_line == LAST_LINE) ? '0 : eff_line + 1'b1;
            end else begin
                pixel_next = eff_pix + 1'b1;
            end
        end
    end

    // Beat and line counters; they hold while no beat is present.
    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            pixel_count <= '0;
            line_count  <= '0;
        end else begin
            pixel_count <= pixel_next;
            line_count  <= line_next;
        end
    end

    // Gain shadow registers, refreshed only at frame start.
    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            gain_r_q <= UNITY;
            gain_g_q <= UNITY;
            gain_b_q <= UNITY;
        end else if (fs) begin
            gain_r_q <= i_gain_r;
            gain_g_q <= i_gain_g;
            gain_b_q <= i_gain_b;
        end
    end

    // CFA site colour of each lane from the pattern phase and line parity.
    always_comb begin
        col0 = COL_G;
        col1 = COL_G;
        case (BAYER_PATTERN)
            0:       begin col0 = eff_line[0] ? COL_G : COL_R; col1 = eff_line[0] ? COL_B : COL_G; end
            1:       begin col0 = eff_line[0] ? COL_B : COL_G; col1 = eff_line[0] ? COL_G : COL_R; end
            2:       begin col0 = eff_line[0] ? COL_R : COL_G; col1 = eff_line[0] ? COL_G : COL_B; end
            default: begin col0 = eff_line[0] ? COL_G : COL_B; col1 = eff_line[0] ? COL_R : COL_G; end
        endcase
    end

    // Route each lane's own sample of the chosen colour bus with its gain.
    always_comb begin
        samp0 = i_g[P_DEPTH-1:0];
        gain0 = gain_g_eff;
        samp1 = i_g[PW-1:P_DEPTH];
        gain1 = gain_g_eff;
        case (col0)
            COL_R:   begin samp0 = i_r[P_DEPTH-1:0]; gain0 = gain_r_eff; end
            COL_B:   begin samp0 = i_b[P_DEPTH-1:0]; gain0 = gain_b_eff; end
            default: begin samp0 = i_g[P_DEPTH-1:0]; gain0 = gain_g_eff; end
        endcase
        case (col1)
            COL_R:   begin samp1 = i_r[PW-1:P_DEPTH]; gain1 = gain_r_eff; end
            COL_B:   begin samp1 = i_b[PW-1:P_DEPTH]; gain1 = gain_b_eff; end
            default: begin samp1 = i_g[PW-1:P_DEPTH]; gain1 = gain_g_eff; end
        endcase
    end

    // Stage 1: capture selected samples, gains and framing flags; idle beats carry zeros.
    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            vsync_q  <= 1'b0;
            s1_valid <= 1'b0;
            s1_sol   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_samp0 <= '0;
            s1_samp1 <= '0;
            s1_gain0 <= '0;
            s1_gain1 <= '0;
        end else begin
            vsync_q  <= i_vsync;
            s1_valid <= i_valid;
            s1_sol   <= i_valid && (eff_pix == '0);
            s1_eol   <= i_valid && (eff_pix == LAST_BEAT);
            s1_samp0 <= i_valid ? samp0 : '0;
            s1_samp1 <= i_valid ? samp1 : '0;
            s1_gain0 <= i_valid ? gain0 : '0;
            s1_gain1 <= i_valid ? gain1 : '0;
        end
    end

    // Fixed-point gain: truncate the fraction, then clamp to full scale.
    always_comb begin
        prod0  = MW'(s1_samp0) * MW'(s1_gain0);
        prod1  = MW'(s1_samp1) * MW'(s1_gain1);
        shift0 = prod0 >> GAIN_FRAC;
        shift1 = prod1 >> GAIN_FRAC;
        sat0   = (shift0 > SAT_MAX) ? '1 : shift0[P_DEPTH-1:0];
        sat1   = (shift1 > SAT_MAX) ? '1 : shift1[P_DEPTH-1:0];
    end

    // Stage 2: registered outputs.
    always_ff @(posedge i_pclk or posedge i_arst) begin
        if (i_arst) begin
            o_vsync <= 1'b0;
            o_valid <= 1'b0;
            o_sol   <= 1'b0;
            o_eol   <= 1'b0;
            o_raw   <= '0;
        end else begin
            o_vsync <= vsync_q;
            o_valid <= s1_valid;
            o_sol   <= s1_sol;
            o_eol   <= s1_eol;
            o_raw   <= s1_valid ? {sat1, sat0} : '0;
        end
    end

endmodule
